// File: rtl/ntt_bram_responder_if.sv
// Host BRAM port plus the X/Y streams between the responder and the NTT core.
// The master side is driven by the host and core; the slave side is the responder.
interface ntt_bram_responder_if;
  logic [11:0] BRAM_addr;
  logic [63:0] BRAM_din;
  logic [63:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_we;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_data;
  logic        tx_last;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] rx_data;
  logic        rx_last;

  modport master (
    output BRAM_addr, BRAM_din, BRAM_en, BRAM_we, tx_ready, rx_valid, rx_data, rx_last,
    input  BRAM_dout, tx_valid, tx_data, tx_last, rx_ready
  );

  modport slave (
    input  BRAM_addr, BRAM_din, BRAM_en, BRAM_we, tx_ready, rx_valid, rx_data, rx_last,
    output BRAM_dout, tx_valid, tx_data, tx_last, rx_ready
  );
endinterface

// File: rtl/ntt_bram_responder.sv
// Memory-side responder for the NTT host BRAM port: holds X/Y buffers, streams X to
// the core, captures the core's results into Y and reports run status.
module ntt_bram_responder #(
  parameter int N            = 64,
  parameter int ADDR_LSB     = 2,
  parameter int READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  ntt_bram_responder_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [11:0]   X_END    = 12'(N);
  localparam logic [11:0]   CTRL_W   = 12'(2 * N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RECV = 2'd2, DONE = 2'd3} state_t;

  state_t        state_r, state_nx;
  logic [63:0]   x_mem [N];
  logic [63:0]   y_mem [N];

  logic [11:0]   word_s;
  logic [IW-1:0] widx_s;
  logic          x_hit_s, y_hit_s, ctrl_hit_s, wr_s, rd_s, idle_done_s;
  logic          start_s, clear_s, x_wr_s, x_wr_bad_s;
  logic          busy_s, done_s, err_r;
  logic [63:0]   status_s, rd_mux_s;

  logic [IW-1:0] fetch_idx_r, k_r;
  logic          fetch_all_r, issue_s, pop_s, rx_hs_s, rx_err_s;
  logic [1:0]    held_s, stored_s;
  logic [63:0]   xq_r, sk_data_r, tx_data_r;
  logic          rd_vld_r, rd_last_r, sk_valid_r, sk_last_r;
  logic          tx_valid_r, tx_last_r, rx_ready_r;
  logic          p1_vld_r;
  logic [63:0]   p1_data_r, dout_r;

  assign word_s      = bus.BRAM_addr >> ADDR_LSB;
  assign widx_s      = word_s[IW-1:0];
  assign x_hit_s     = (word_s < X_END);
  assign y_hit_s     = (word_s >= X_END) && (word_s < CTRL_W);
  assign ctrl_hit_s  = (word_s == CTRL_W);
  assign wr_s        = bus.BRAM_en & bus.BRAM_we;
  assign rd_s        = bus.BRAM_en & ~bus.BRAM_we;
  assign idle_done_s = (state_r == IDLE) || (state_r == DONE);
  assign start_s     = wr_s & ctrl_hit_s & bus.BRAM_din[0] & idle_done_s;
  assign clear_s     = wr_s & ctrl_hit_s & bus.BRAM_din[1] & (state_r == DONE);
  assign x_wr_s      = wr_s & x_hit_s & idle_done_s;
  assign x_wr_bad_s  = wr_s & x_hit_s & ~idle_done_s;
  assign busy_s      = (state_r == SEND) || (state_r == RECV);
  assign done_s      = (state_r == DONE);
  assign status_s    = {61'd0, err_r, done_s, busy_s};

  // Prefetch pipeline: read stage, skid slot and output slot hold at most two words,
  // so a new read is issued only when it will find room the following cycle.
  assign pop_s    = tx_valid_r & bus.tx_ready;
  assign held_s   = {1'b0, tx_valid_r} + {1'b0, sk_valid_r} + {1'b0, rd_vld_r};
  assign stored_s = held_s - {1'b0, pop_s};
  assign issue_s  = (state_r == SEND) && !fetch_all_r && (stored_s < 2'd2);
  assign rx_hs_s  = bus.rx_valid & rx_ready_r;
  assign rx_err_s = rx_hs_s & (bus.rx_last != (k_r == LAST_IDX));

  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.tx_last   = tx_last_r;
  assign bus.rx_ready  = rx_ready_r;
  assign bus.BRAM_dout = dout_r;

  // Next-state logic of the run sequencer.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: if (start_s) state_nx = SEND; else state_nx = IDLE;
      SEND: if (pop_s && tx_last_r) state_nx = RECV; else state_nx = SEND;
      RECV: if (rx_hs_s && (k_r == LAST_IDX)) state_nx = DONE; else state_nx = RECV;
      DONE: begin
        if (start_s)      state_nx = SEND;
        else if (clear_s) state_nx = IDLE;
        else              state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // Buffer RAMs; not reset. Y reads below see the pre-write value (read-first).
  always_ff @(posedge clk) begin
    if (x_wr_s)  x_mem[widx_s] <= bus.BRAM_din;
    if (rx_hs_s) y_mem[k_r]    <= bus.rx_data;
    if (issue_s) xq_r          <= x_mem[fetch_idx_r];
  end

  // X stream: fetch counter, skid slot and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_idx_r <= '0;
      fetch_all_r <= 1'b0;
      rd_vld_r    <= 1'b0;
      rd_last_r   <= 1'b0;
      sk_valid_r  <= 1'b0;
      sk_data_r   <= 64'd0;
      sk_last_r   <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 64'd0;
      tx_last_r   <= 1'b0;
    end else begin
      rd_vld_r <= issue_s;
      if (start_s) begin
        fetch_idx_r <= '0;
        fetch_all_r <= 1'b0;
      end else if (issue_s) begin
        rd_last_r   <= (fetch_idx_r == LAST_IDX);
        fetch_idx_r <= fetch_idx_r + ONE_IDX;
        fetch_all_r <= (fetch_idx_r == LAST_IDX);
      end
      if (pop_s || !tx_valid_r) begin
        if (sk_valid_r) begin
          tx_data_r  <= sk_data_r;
          tx_last_r  <= sk_last_r;
          sk_valid_r <= rd_vld_r;
          sk_data_r  <= xq_r;
          sk_last_r  <= rd_last_r;
        end else if (rd_vld_r) begin
          tx_valid_r <= 1'b1;
          tx_data_r  <= xq_r;
          tx_last_r  <= rd_last_r;
        end else begin
          tx_valid_r <= 1'b0;
        end
      end else if (rd_vld_r) begin
        sk_valid_r <= 1'b1;
        sk_data_r  <= xq_r;
        sk_last_r  <= rd_last_r;
      end
    end
  end

  // Result capture index, rx_ready and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r        <= '0;
      rx_ready_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rx_ready_r <= (state_nx == RECV);
      if (start_s)      k_r <= '0;
      else if (rx_hs_s) k_r <= k_r + ONE_IDX;
      if (start_s || clear_s)          err_r <= 1'b0;
      else if (x_wr_bad_s || rx_err_s) err_r <= 1'b1;
    end
  end

  // Host read data selection for the current address.
  always_comb begin
    rd_mux_s = 64'd0;
    if (x_hit_s)         rd_mux_s = x_mem[widx_s];
    else if (y_hit_s)    rd_mux_s = y_mem[widx_s];
    else if (ctrl_hit_s) rd_mux_s = status_s;
    else                 rd_mux_s = 64'd0;
  end

  // Host read pipeline; dout only changes when a read result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld_r  <= 1'b0;
      p1_data_r <= 64'd0;
      dout_r    <= 64'd0;
    end else begin
      p1_vld_r <= rd_s;
      if (rd_s) p1_data_r <= rd_mux_s;
      if (READ_LATENCY == 1) begin
        if (rd_s) dout_r <= rd_mux_s;
      end else begin
        if (p1_vld_r) dout_r <= p1_data_r;
      end
    end
  end
endmodule

// File: tb/tb_ntt_bram_responder.sv
// Directed bench for ntt_bram_responder: host port tasks, a core model on the streams,
// and queues of expected tx beats and read data.
module tb_ntt_bram_responder;
  localparam int N    = 64;
  localparam int RL   = 1;
  localparam int CTRL = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_bram_responder_if bus();

  ntt_bram_responder #(.N(N), .ADDR_LSB(2), .READ_LATENCY(RL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] xm [N];
  logic [64:0] tx_q [$];
  logic [63:0] rd_q [$];
  bit          mon_en = 1'b0;
  bit          tx_mode = 1'b0;
  bit          tog = 1'b0;
  bit          rx_en = 1'b0;
  bit          stalled = 1'b0;
  bit          rx_hs = 1'b0;
  logic [63:0] held = 64'd0;
  logic [64:0] exp_beat;
  int          tx_beats = 0;
  int          k_core = 0;
  int          rx_last_at = N - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core-side tx_ready: constant 1 or toggling 1010..
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tog = ~tog;
      bus.tx_ready = tx_mode ? tog : 1'b1;
    end
  end

  // tx monitor: pops the expected beat on each handshake, checks stability while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stalled = 1'b0;
      end else if (bus.tx_valid) begin
        if (stalled) chk("tx_hold_data", bus.tx_data, held);
        if (bus.tx_ready) begin
          stalled = 1'b0;
          tx_beats++;
          if (tx_q.size() == 0) begin
            chk("tx_extra_beat", 64'(tx_q.size()), 64'd1);
          end else begin
            exp_beat = tx_q.pop_front();
            chk("tx_data", bus.tx_data, exp_beat[63:0]);
            chk("tx_last", 64'(bus.tx_last), 64'(exp_beat[64]));
          end
        end else begin
          stalled = 1'b1;
          held = bus.tx_data;
        end
      end
    end
  end

  // Core result model: returns ~X[k], rx_last at beat rx_last_at.
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 64'd0;
    bus.rx_last  = 1'b0;
    forever begin
      @(negedge clk);
      rx_hs = bus.rx_valid && bus.rx_ready;
      @(posedge clk); #1;
      if (rx_hs) k_core++;
      bus.rx_valid = rx_en && (k_core < N);
      bus.rx_data  = ~xm[k_core % N];
      bus.rx_last  = (k_core == rx_last_at);
    end
  end

  task automatic host_wr(input int w, input logic [63:0] d);
    @(posedge clk); #1;
    bus.BRAM_en = 1'b1; bus.BRAM_we = 1'b1; bus.BRAM_addr = 12'(w << 2); bus.BRAM_din = d;
    @(posedge clk); #1;
    bus.BRAM_en = 1'b0; bus.BRAM_we = 1'b0;
  endtask

  task automatic host_rd(input int w, output logic [63:0] d);
    @(posedge clk); #1;
    bus.BRAM_en = 1'b1; bus.BRAM_we = 1'b0; bus.BRAM_addr = 12'(w << 2);
    @(posedge clk); #1;
    bus.BRAM_en = 1'b0;
    for (int i = 1; i < RL; i++) begin
      @(posedge clk); #1;
    end
    d = bus.BRAM_dout;
  endtask

  task automatic host_chk(input int w, input logic [63:0] exp, input string tag);
    logic [63:0] d;
    rd_q.push_back(exp);
    host_rd(w, d);
    chk(tag, d, rd_q.pop_front());
  endtask

  task automatic push_stream();
    for (int i = 0; i < N; i++) tx_q.push_back({(i == N - 1) ? 1'b1 : 1'b0, xm[i]});
  endtask

  task automatic wait_tx_empty(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tx_q.size() == 0) break;
    end
    chk(tag, 64'(tx_q.size()), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < 300; i++) begin
      host_rd(CTRL, s);
      if (s[1]) break;
    end
    chk(tag, 64'(s[1]), 64'd1);
  endtask

  initial begin
    bus.BRAM_en = 1'b0; bus.BRAM_we = 1'b0; bus.BRAM_addr = 12'd0; bus.BRAM_din = 64'd0;
    for (int i = 0; i < N; i++) xm[i] = 64'(i + 1);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_tx_data", bus.tx_data, 64'd0);
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_dout", bus.BRAM_dout, 64'd0);
    rst = 1'b0;

    // Status and unmapped reads
    host_chk(CTRL, 64'd0, "ctrl_after_rst");
    host_chk(200, 64'd0, "unmapped_rd");
    host_wr(200, 64'hFFFF);
    host_chk(200, 64'd0, "unmapped_after_wr");

    // Fill X, stream with tx_ready held high
    for (int i = 0; i < N; i++) host_wr(i, xm[i]);
    tx_mode = 1'b0; rx_en = 1'b0; mon_en = 1'b1; tx_beats = 0;
    push_stream();
    host_wr(CTRL, 64'd1);
    @(posedge clk); @(posedge clk); #1;
    chk("first_tx_within_2", 64'(bus.tx_valid), 64'd1);
    host_chk(CTRL, 64'd1, "status_busy_send");
    wait_tx_empty("t2_stream_drained");
    chk("t2_beats", 64'(tx_beats), 64'(N));
    host_chk(CTRL, 64'd1, "status_busy_recv");
    k_core = 0; rx_last_at = N - 1; rx_en = 1'b1;
    wait_done("t2_done_in_time");
    host_chk(CTRL, 64'd2, "t2_status_done");
    chk("t2_rx_count", 64'(k_core), 64'(N));
    rx_en = 1'b0;

    // Stalling tx_ready, core results offered during SEND
    tx_beats = 0; tx_mode = 1'b1; k_core = 0; rx_en = 1'b1;
    push_stream();
    host_wr(CTRL, 64'd1);
    wait_tx_empty("t3_stream_drained");
    chk("t3_beats", 64'(tx_beats), 64'(N));
    wait_done("t3_done_in_time");
    host_chk(CTRL, 64'd2, "t3_status_done");
    rx_en = 1'b0;
    for (int k = 0; k < N; k++) host_chk(N + k, ~xm[k], "y_readback");
    host_wr(N + 3, 64'h1234);
    host_chk(N + 3, ~xm[3], "y_write_dropped");

    // Misplaced rx_last, X write and start while busy
    tx_mode = 1'b0; tx_beats = 0; k_core = 0; rx_last_at = 10; rx_en = 1'b1;
    push_stream();
    host_wr(CTRL, 64'd1);
    host_wr(5, 64'hDEAD);
    host_wr(CTRL, 64'd1);
    host_chk(CTRL, 64'd5, "t5_busy_err");
    wait_tx_empty("t5_stream_drained");
    chk("t5_beats", 64'(tx_beats), 64'(N));
    wait_done("t5_done_in_time");
    host_chk(CTRL, 64'd6, "t5_status_err_done");
    chk("t5_rx_count", 64'(k_core), 64'(N));
    host_chk(5, xm[5], "x_unchanged");
    host_wr(CTRL, 64'd2);
    host_chk(CTRL, 64'd0, "clear_status");
    rx_en = 1'b0; rx_last_at = N - 1;

    // Reset in the middle of SEND
    tx_beats = 0;
    push_stream();
    host_wr(CTRL, 64'd1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_beats >= 20) break;
    end
    chk("t6_reached_beat20", 64'(tx_beats >= 20), 64'd1);
    mon_en = 1'b0; rst = 1'b1;
    tx_q.delete();
    @(posedge clk); #1;
    chk("t6_tx_valid_rst", 64'(bus.tx_valid), 64'd0);
    chk("t6_tx_last_rst", 64'(bus.tx_last), 64'd0);
    chk("t6_rx_ready_rst", 64'(bus.rx_ready), 64'd0);
    rst = 1'b0;
    host_chk(CTRL, 64'd0, "t6_status_after_rst");
    mon_en = 1'b1; tx_beats = 0;
    push_stream();
    host_wr(CTRL, 64'd1);
    wait_tx_empty("t6_restream_drained");
    chk("t6_beats", 64'(tx_beats), 64'(N));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
